// File: rtl/qbert_switch_irq_ctrl.sv
// Switch debouncer, edge-capture and level-IRQ controller as an Avalon-MM slave.
// Define SWITCH_BOTHEDGE_EN to capture falling as well as rising debounced edges.
module qbert_switch_irq_ctrl #(
    parameter int unsigned WIDTH        = 4,
    parameter logic [15:0] PERIOD_RESET = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    typedef enum logic {ST_STABLE, ST_PENDING} state_t;

    state_t           state      [WIDTH];
    state_t           state_next [WIDTH];
    logic [WIDTH-1:0] sync_a, sync, stable, stable_d, sample;
    logic [WIDTH-1:0] load_sample, accept, edges, clr;
    logic [WIDTH-1:0] mask, edgecap;
    logic [15:0]      period, count, period_eff;
    logic             tick, wr_period, wr_mask, wr_cap;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    assign wr_period = chipselect & write & (address == 2'd1);
    assign wr_mask   = chipselect & write & (address == 2'd2);
    assign wr_cap    = chipselect & write & (address == 2'd3);
    assign clr       = wr_cap ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // A programmed period of 0 ticks every cycle, same as 1.
    assign period_eff = (period == '0) ? 16'd1 : period;
    assign tick       = (count == period_eff - 16'd1);

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state[i] <= reset ? ST_STABLE : state_next[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state_next[i] = state[i];
            if (tick) begin
                case (state[i])
                    ST_STABLE:  if (sync[i] != stable[i]) state_next[i] = ST_PENDING;
                    ST_PENDING: state_next[i] = ST_STABLE;
                endcase
            end
        end
    end

    always_comb begin
        load_sample = '0;
        accept      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (tick && state[i] == ST_STABLE && sync[i] != stable[i]) load_sample[i] = 1'b1;
            if (tick && state[i] == ST_PENDING && sync[i] == sample[i]) accept[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= '0;
            sync     <= '0;
            stable   <= '0;
            stable_d <= '0;
            sample   <= '0;
        end else begin
            sync_a   <= in_port;
            sync     <= sync_a;
            stable_d <= stable;
            sample   <= (sample & ~load_sample) | (sync & load_sample);
            stable   <= (stable & ~accept) | (sync & accept);
        end
    end

`ifdef SWITCH_BOTHEDGE_EN
    assign edges = stable ^ stable_d;
`else
    assign edges = stable & ~stable_d;
`endif

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = stable;
            2'd1:    rd_next[15:0]      = period;
            2'd2:    rd_next[WIDTH-1:0] = mask;
            default: rd_next[WIDTH-1:0] = edgecap;
        endcase
    end

    // Edge set is OR'd after the W1C clear so a same-cycle set survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            period   <= PERIOD_RESET;
            count    <= '0;
            mask     <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (wr_period) begin
                period <= writedata[15:0];
                count  <= '0;
            end else if (tick) begin
                count <= '0;
            end else begin
                count <= count + 16'd1;
            end
            if (wr_mask) mask <= writedata[WIDTH-1:0];
            edgecap  <= (edgecap & ~clr) | edges;
            irq      <= |(edgecap & mask);
            readdata <= rd_next;
        end
    end
endmodule

// File: tb/tb_qbert_switch_irq_ctrl.sv
// Scoreboard bench for qbert_switch_irq_ctrl: a behavioural model predicts readdata/irq
// every cycle; directed scenarios add fixed-value checks. Honours SWITCH_BOTHEDGE_EN.
module tb_qbert_switch_irq_ctrl;
    localparam int unsigned W  = 4;
    localparam logic [15:0] PR = 16'd8;

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write      = 1'b0;
    logic [31:0]   writedata  = '0;
    logic [W-1:0]  in_port    = '0;
    logic [31:0]   readdata;
    logic          irq;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    qbert_switch_irq_ctrl #(.WIDTH(W), .PERIOD_RESET(PR)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: input history queue gives the synchronised view, ticks come from
    // elapsed cycles modulo the period, each bit remembers a candidate level between ticks.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_stable, m_prev, m_mask, m_cap, m_cand, m_pend, m_sync, m_set, m_clr;
    logic [15:0]  m_period;
    int unsigned  m_since, m_p;
    bit           m_on = 1'b0;
    bit           m_tick;
    exp_t         m_e;

    always @(posedge clk) begin
        if (reset) begin
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
            m_stable = '0; m_prev = '0; m_mask = '0; m_cap = '0; m_cand = '0; m_pend = '0;
            m_period = PR;
            m_since  = 0;
            m_on     = 1'b1;
            m_e.rd   = '0;
            m_e.irq  = 1'b0;
            exp_q.push_back(m_e);
        end else if (m_on) begin
            m_sync = m_hist.pop_front();
            m_hist.push_back(in_port);
            m_p = m_period;
            if (m_p == 0) m_p = 1;
            m_tick = (m_since % m_p) == (m_p - 1);
            m_e.rd = '0;
            case (address)
                2'd0:    m_e.rd[W-1:0] = m_stable;
                2'd1:    m_e.rd[15:0]  = m_period;
                2'd2:    m_e.rd[W-1:0] = m_mask;
                default: m_e.rd[W-1:0] = m_cap;
            endcase
            m_e.irq = |(m_cap & m_mask);
`ifdef SWITCH_BOTHEDGE_EN
            m_set = m_stable ^ m_prev;
`else
            m_set = m_stable & ~m_prev;
`endif
            m_clr = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
            m_cap = (m_cap & ~m_clr) | m_set;
            m_prev = m_stable;
            if (m_tick) begin
                for (int i = 0; i < W; i++) begin
                    if (m_pend[i]) begin
                        if (m_sync[i] == m_cand[i]) m_stable[i] = m_sync[i];
                        m_pend[i] = 1'b0;
                    end else if (m_sync[i] != m_stable[i]) begin
                        m_pend[i] = 1'b1;
                        m_cand[i] = m_sync[i];
                    end
                end
            end
            if (chipselect && write && address == 2'd1) begin
                m_period = writedata[15:0];
                m_since  = 0;
            end else begin
                m_since++;
            end
            if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
            exp_q.push_back(m_e);
        end
    end

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (readdata !== mon_e.rd) begin
                errors++;
                $display("FAIL sb_readdata t=%0t got=%h want=%h", $time, readdata, mon_e.rd);
            end
            checks++;
            if (irq !== mon_e.irq) begin
                errors++;
                $display("FAIL sb_irq t=%0t got=%b want=%b", $time, irq, mon_e.irq);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [31:0] want, input string name);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
        chk(name, readdata, want);
    endtask

    task automatic wait_rd(input logic [31:0] m, input logic [31:0] v, input int maxc, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(posedge clk);
            #1;
            if ((readdata & m) == v) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    bit bounce_seen;
    int idx;

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        read_chk(2'd0, 32'd0, "rst_data");
        read_chk(2'd1, 32'd8, "rst_period");
        read_chk(2'd2, 32'd0, "rst_mask");
        read_chk(2'd3, 32'd0, "rst_edgecap");
        chk("rst_irq", 32'(irq), 32'd0);

        // Clean press on bit 0
        write_reg(2'd1, 32'd4);
        write_reg(2'd2, 32'd1);
        address = 2'd0;
        in_port[0] = 1'b1;
        wait_rd(32'd1, 32'd1, 14, "press_data");
        chk("press_irq_pre", 32'(irq), 32'd0);
        @(negedge clk);
        address = 2'd3;
        @(posedge clk);
        #1;
        chk("press_edgecap", readdata, 32'd1);
        chk("press_irq", 32'(irq), 32'd1);
        write_reg(2'd3, 32'd1);
        @(posedge clk);
        #1;
        chk("w1c_edgecap", readdata, 32'd0);
        chk("w1c_irq", 32'(irq), 32'd0);

        // Bounce on bit 1, phased so every tick samples the low half
        write_reg(2'd1, 32'd4);
        address = 2'd0;
        bounce_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_port[1] = ((c / 2) % 2) != 0;
            @(negedge clk);
            if (readdata[1]) bounce_seen = 1'b1;
        end
        in_port[1] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (readdata[1]) bounce_seen = 1'b1;
        end
        chk("bounce_data", 32'(bounce_seen), 32'd0);
        read_chk(2'd3, 32'd0, "bounce_edgecap");

        // Masked capture on bit 2
        write_reg(2'd2, 32'd0);
        address = 2'd3;
        in_port[2] = 1'b1;
        wait_rd(32'd4, 32'd4, 14, "mask_edgecap_set");
        chk("mask_edgecap", readdata, 32'd4);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("mask_irq", 32'(irq), 32'd0);
        end
        @(negedge clk);
        in_port[2] = 1'b0;
        repeat (14) @(negedge clk);
        write_reg(2'd3, 32'd4);
        read_chk(2'd3, 32'd0, "mask_clear");

        // W1C landing on the same edge as a new bit-2 rise (tick every cycle)
        write_reg(2'd1, 32'd0);
        @(negedge clk);
        in_port[2] = 1'b1;
        repeat (4) @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 2'd3; writedata = 32'd4;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        @(posedge clk);
        #1;
        chk("collision_edgecap", readdata, 32'd4);

        // Release edge on bit 3
        write_reg(2'd3, 32'hF);
        in_port[3] = 1'b1;
        repeat (8) @(negedge clk);
        read_chk(2'd3, 32'd8, "rel_press_edgecap");
        write_reg(2'd3, 32'd8);
        in_port[3] = 1'b0;
        repeat (8) @(negedge clk);
`ifdef SWITCH_BOTHEDGE_EN
        read_chk(2'd3, 32'd8, "rel_release_edgecap");
`else
        read_chk(2'd3, 32'd0, "rel_release_edgecap");
`endif
        read_chk(2'd0, 32'd5, "rel_data");

        // PERIOD=0 latency: stable moves on the 4th edge after the change
        @(negedge clk);
        address = 2'd0;
        in_port[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("p0_data_hold", 32'(readdata[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("p0_data_follow", 32'(readdata[0]), 32'd0);

        // Reset while bit 1 is pending
        write_reg(2'd1, 32'd8);
        in_port[1] = 1'b1;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        address = 2'd3;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstp_edgecap", readdata, 32'd0);
        chk("rstp_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        chk("rstp_edgecap2", readdata, 32'd0);
        read_chk(2'd1, 32'd8, "rstp_period");
        read_chk(2'd0, 32'd0, "rstp_data");
        read_chk(2'd2, 32'd0, "rstp_mask");

        // Randomised traffic, checked by the scoreboard
        in_port = '0;
        write_reg(2'd2, 32'hF);
        for (int n = 0; n < 500; n++) begin
            reset   = (n == 250);
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                chipselect = 1'b1;
                write      = 1'b1;
                writedata  = $urandom;
                if (address == 2'd1) writedata = $urandom_range(0, 5);
            end else begin
                chipselect = 1'($urandom_range(0, 1));
                write      = ~chipselect & 1'($urandom_range(0, 1));
                writedata  = $urandom;
            end
            if ($urandom_range(0, 9) == 0) begin
                idx = $urandom_range(0, W - 1);
                in_port[idx] = ~in_port[idx];
            end
            @(negedge clk);
        end
        reset = 1'b0;
        chipselect = 1'b0;
        write = 1'b0;
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
